// File: rtl/msrv32_pkg.sv
// Shared types and constants for the load/store bus controller and the
// writeback-side load alignment logic.
package msrv32_pkg;

  // Bus controller states: one transaction at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_t;

  // Access size codes as produced by the decoder (2'b11 also means word).
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // Default number of WAIT cycles before an unanswered access is a bus fault.
  localparam int DEFAULT_TIMEOUT = 255;

  // Byte enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lsu_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      LS_BYTE: m = 4'b0001 << off;
      LS_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated across all lanes so the mask alone selects bytes.
  function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      LS_BYTE: w = {4{data[7:0]}};
      LS_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/msrv32_lsu_bus_ctrl_if.sv
// Data-memory req/ack bus between the load/store controller and a slave.
//
// Handshake: the master raises dmem_req_out and holds address, we, mask and
// wdata stable until the slave answers with a single-cycle dmem_ack_in; read
// data and the error flag are only meaningful in the ack cycle. The request
// drops on the edge that samples ack (or on timeout). Ack with no request
// outstanding is ignored by the master.
interface msrv32_lsu_bus_ctrl_if;
  import msrv32_pkg::*;

  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic        dmem_err_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
    input  dmem_ack_in, dmem_rdata_in, dmem_err_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
    output dmem_ack_in, dmem_rdata_in, dmem_err_in
  );

endinterface

// File: rtl/msrv32_load_align.sv
// Combinational load alignment: selects the addressed byte/half lane of a
// read word and sign- or zero-extends it to 32 bits.
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] rdata_in,
  input  logic [1:0]  offset_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection from the low address bits.
  always_comb begin
    byte_sel = rdata_in[7:0];
    case (offset_in)
      2'd0:    byte_sel = rdata_in[7:0];
      2'd1:    byte_sel = rdata_in[15:8];
      2'd2:    byte_sel = rdata_in[23:16];
      default: byte_sel = rdata_in[31:24];
    endcase
    half_sel = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];
  end

  // Extension by access size; word loads pass through untouched.
  always_comb begin
    data_out = rdata_in;
    case (size_in)
      LS_BYTE: data_out = {{24{byte_sel[7] & ~unsigned_in}}, byte_sel};
      LS_HALF: data_out = {{16{half_sel[15] & ~unsigned_in}}, half_sel};
      default: data_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/msrv32_lsu_bus_ctrl.sv
// Load/store bus controller: accepts one decoded memory access at a time,
// runs it over the req/ack data bus, stalls the pipeline while it is
// outstanding, and returns extended load data or a bus-fault pulse.
module msrv32_lsu_bus_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         ld_req_in,
  input  logic                         mem_wr_req_in,
  input  logic [1:0]                   load_size_in,
  input  logic                         load_unsigned_in,
  input  logic                         misaligned_load_in,
  input  logic                         misaligned_store_in,
  input  logic                         trap_taken_in,
  input  logic [31:0]                  addr_in,
  input  logic [31:0]                  rs2_in,
  msrv32_lsu_bus_ctrl_if.master        dmem_bus,
  output logic                         stall_out,
  output logic [31:0]                  load_data_out,
  output logic                         load_valid_out,
  output logic                         bus_err_out,
  output lsu_state_t                   dbg_state_out
);

  // Last WAIT-cycle count value before the access is declared dead.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic        trap_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        bus_err_q;

  logic        is_store_d;
  logic        misaligned_d;
  logic        start_d;
  logic        suppress_d;
  logic [31:0] load_ext_d;

  // Start qualification: a store beats a simultaneous load, and the
  // misalignment flag that matters follows the winning access type.
  always_comb begin
    is_store_d   = mem_wr_req_in;
    misaligned_d = is_store_d ? misaligned_store_in : misaligned_load_in;
    start_d      = (ld_req_in | mem_wr_req_in) & ~trap_taken_in & ~misaligned_d;
    suppress_d   = trap_q | trap_taken_in;
  end

  // Extended load data from the live bus word and the captured lane info.
  msrv32_load_align u_align (
    .rdata_in    (dmem_bus.dmem_rdata_in),
    .offset_in   (off_q),
    .size_in     (size_q),
    .unsigned_in (uns_q),
    .data_out    (load_ext_d)
  );

  // Transaction FSM with its capture registers, timeout counter and outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q <= ST_WAIT;
            req_q   <= 1'b1;
            we_q    <= is_store_d;
            addr_q  <= {addr_in[31:2], 2'b00};
            wmask_q <= lsu_mask(load_size_in, addr_in[1:0]);
            wdata_q <= lsu_wdata(load_size_in, rs2_in);
            size_q  <= load_size_in;
            uns_q   <= load_unsigned_in;
            off_q   <= addr_in[1:0];
            cnt_q   <= '0;
            trap_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A trap never abandons the bus access; it only hides the result.
          if (trap_taken_in) begin
            trap_q <= 1'b1;
          end
          if (dmem_bus.dmem_ack_in) begin
            req_q <= 1'b0;
            if (dmem_bus.dmem_err_in) begin
              state_q   <= ST_ERR;
              bus_err_q <= ~suppress_d;
            end else begin
              state_q <= ST_RESP;
              if (!we_q && !suppress_d) begin
                load_valid_q <= 1'b1;
                load_data_q  <= load_ext_d;
              end
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            req_q     <= 1'b0;
            state_q   <= ST_ERR;
            bus_err_q <= ~suppress_d;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the accepting cycle and every WAIT cycle; it is forced low
  // while reset is asserted so all outputs read zero.
  always_comb begin
    stall_out = rst_n_in & (((state_q == ST_IDLE) & start_d) | (state_q == ST_WAIT));
  end

  assign dmem_bus.dmem_req_out   = req_q;
  assign dmem_bus.dmem_we_out    = we_q;
  assign dmem_bus.dmem_addr_out  = addr_q;
  assign dmem_bus.dmem_wdata_out = wdata_q;
  assign dmem_bus.dmem_wmask_out = wmask_q;
  assign load_data_out           = load_data_q;
  assign load_valid_out          = load_valid_q;
  assign bus_err_out             = bus_err_q;
  assign dbg_state_out           = state_q;

endmodule
